// File: rtl/control_unit_if.sv
// Instruction handshake between the instruction source and the sequencer.
// Latency: none, plain wires.
// Backpressure: the source holds instr/instrValid until ready is seen high.
interface control_unit_if;
    logic [15:0] instr;
    logic        instrValid;
    logic        ready;
    logic        done;
    logic        err;

    modport master (
        output instr,
        output instrValid,
        input  ready,
        input  done,
        input  err
    );

    modport slave (
        input  instr,
        input  instrValid,
        output ready,
        output done,
        output err
    );
endinterface

// File: rtl/control_unit.sv
// Sequencer for the 16-bit single-bus datapath: decodes one instruction and walks its strobe sequence.
// Latency: done in cycle ALU 5, MOV 2, LOAD 5+w, STORE 4+w, OUT 2, IN 3, PC 2, NOP 1 after the accept edge.
// Backpressure: ready only in IDLE; memory states stall on MFC (bounded by MFC_TIMEOUT when CU_MFC_TIMEOUT_EN is defined).
module control_unit #(
    parameter int MFC_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    control_unit_if.slave bus,
    input  logic         MFC,
    output logic [2:0]   opControl,
    output logic         ALUin0,
    output logic         ALUin1,
    output logic         ALUOutLatch,
    output logic         ALUOutEn,
    output logic         PCOutEn,
    output logic         r0Latch,
    output logic         r1Latch,
    output logic         r2Latch,
    output logic         r3Latch,
    output logic         r0Out,
    output logic         r1Out,
    output logic         r2Out,
    output logic         r3Out,
    output logic         memEN,
    output logic         memRW,
    output logic         MARin,
    output logic         MDRwriteEN,
    output logic         MDRreadEN,
    output logic         MDRout,
    output logic         p0Latch,
    output logic         p0Out,
    output logic         p1Latch,
    output logic         p1Out
);

    typedef enum logic [4:0] {
        IDLE, ALU_A, ALU_B, ALU_X, ALU_W, XFER,
        L_MAR, L_RD, L_LAT, L_WB,
        S_MAR, S_MDR, S_WR,
        P_OUT, P_SMP, P_WB, PC_WB, DONE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] ir;            // instr[15:8]; the low byte carries no information
    logic       err_q;
    logic       timeout_hit;
    logic       accept;

    logic [3:0] opcode;
    logic [1:0] rd, rs;
    logic [3:0] rd_hot, rs_hot;
    logic       rd_out_en, rs_out_en, rd_latch_en;
    logic [3:0] r_out, r_latch;

    logic       unused_instr_lo;
    assign unused_instr_lo = ^bus.instr[7:0];

    assign opcode = ir[7:4];
    assign rd     = ir[3:2];
    assign rs     = ir[1:0];
    assign rd_hot = 4'b0001 << rd;
    assign rs_hot = 4'b0001 << rs;

    assign accept    = (state == IDLE) && bus.instrValid;
    assign bus.ready = (state == IDLE);
    assign bus.done  = (state == DONE);
    assign bus.err   = (state == DONE) && err_q;

`ifdef CU_MFC_TIMEOUT_EN
    localparam int CW = $clog2(MFC_TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    // Wait counter: zero outside the memory-wait states, counts MFC=0 cycles inside them
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state != L_RD && state != S_WR) begin
            wait_cnt <= '0;
        end else if (!MFC) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Abort on the cycle whose MFC=0 would make the count reach the limit; MFC=1 wins
    assign timeout_hit = (state == L_RD || state == S_WR) && !MFC &&
                         (wait_cnt == CW'(MFC_TIMEOUT - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = MFC_TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    // State, instruction register and abort flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ir    <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= timeout_hit;
            if (accept) begin
                ir <= bus.instr[15:8];
            end
        end
    end

    // Next-state: decode from the offered word in IDLE, then fixed walk per opcode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.instrValid) begin
                    case (bus.instr[15:12])
                        4'h0, 4'h1, 4'h2, 4'h3,
                        4'h4, 4'h5, 4'h6, 4'h7: state_nxt = ALU_A;
                        4'h8:                   state_nxt = XFER;
                        4'h9:                   state_nxt = L_MAR;
                        4'hA:                   state_nxt = S_MAR;
                        4'hB:                   state_nxt = P_OUT;
                        4'hC:                   state_nxt = P_SMP;
                        4'hD:                   state_nxt = PC_WB;
                        default:                state_nxt = DONE;
                    endcase
                end
            end
            ALU_A: state_nxt = ALU_B;
            ALU_B: state_nxt = ALU_X;
            ALU_X: state_nxt = ALU_W;
            ALU_W: state_nxt = DONE;
            XFER:  state_nxt = DONE;
            L_MAR: state_nxt = L_RD;
            L_RD: begin
                if (MFC)              state_nxt = L_LAT;
                else if (timeout_hit) state_nxt = DONE;
            end
            L_LAT: state_nxt = L_WB;
            L_WB:  state_nxt = DONE;
            S_MAR: state_nxt = S_MDR;
            S_MDR: state_nxt = S_WR;
            S_WR: begin
                if (MFC || timeout_hit) state_nxt = DONE;
            end
            P_OUT: state_nxt = DONE;
            P_SMP: state_nxt = P_WB;
            P_WB:  state_nxt = DONE;
            PC_WB: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore strobe decode from state and IR; at most one bus source per state
    always_comb begin
        opControl   = 3'b000;
        ALUin0      = 1'b0;
        ALUin1      = 1'b0;
        ALUOutLatch = 1'b0;
        ALUOutEn    = 1'b0;
        PCOutEn     = 1'b0;
        memEN       = 1'b0;
        memRW       = 1'b0;
        MARin       = 1'b0;
        MDRwriteEN  = 1'b0;
        MDRreadEN   = 1'b0;
        MDRout      = 1'b0;
        p0Latch     = 1'b0;
        p0Out       = 1'b0;
        p1Latch     = 1'b0;
        p1Out       = 1'b0;
        rd_out_en   = 1'b0;
        rs_out_en   = 1'b0;
        rd_latch_en = 1'b0;
        case (state)
            ALU_A: begin opControl = opcode[2:0]; rd_out_en = 1'b1; ALUin0 = 1'b1; end
            ALU_B: begin opControl = opcode[2:0]; rs_out_en = 1'b1; ALUin1 = 1'b1; end
            ALU_X: begin opControl = opcode[2:0]; ALUOutLatch = 1'b1; end
            ALU_W: begin opControl = opcode[2:0]; ALUOutEn = 1'b1; rd_latch_en = 1'b1; end
            XFER:  begin rs_out_en = 1'b1; rd_latch_en = 1'b1; end
            L_MAR: begin rs_out_en = 1'b1; MARin = 1'b1; end
            L_RD:  begin memEN = 1'b1; end
            L_LAT: begin memEN = 1'b1; MDRreadEN = 1'b1; end
            L_WB:  begin MDRout = 1'b1; rd_latch_en = 1'b1; end
            S_MAR: begin rs_out_en = 1'b1; MARin = 1'b1; end
            S_MDR: begin rd_out_en = 1'b1; MDRwriteEN = 1'b1; end
            S_WR:  begin memEN = 1'b1; memRW = 1'b1; end
            P_OUT: begin rd_out_en = 1'b1; p0Latch = 1'b1; end
            P_SMP: begin p1Latch = 1'b1; end
            P_WB:  begin p1Out = 1'b1; rd_latch_en = 1'b1; end
            PC_WB: begin PCOutEn = 1'b1; rd_latch_en = 1'b1; end
            default: ;
        endcase
    end

    assign r_out   = (rd_out_en ? rd_hot : 4'b0000) | (rs_out_en ? rs_hot : 4'b0000);
    assign r_latch = rd_latch_en ? rd_hot : 4'b0000;

    assign {r3Out, r2Out, r1Out, r0Out}         = r_out;
    assign {r3Latch, r2Latch, r1Latch, r0Latch} = r_latch;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class cycle by cycle.
// Latency: checks every cycle from accept to the return to IDLE.
// Backpressure: exercises held instrValid, mid-instruction instr changes and MFC stalls.
module tb_control_unit;

    logic clk = 1'b0;
    logic rst;
    logic MFC;
    always #5 clk = ~clk;

    logic [2:0] opControl;
    logic ALUin0, ALUin1, ALUOutLatch, ALUOutEn, PCOutEn;
    logic r0Latch, r1Latch, r2Latch, r3Latch, r0Out, r1Out, r2Out, r3Out;
    logic memEN, memRW, MARin, MDRwriteEN, MDRreadEN, MDRout;
    logic p0Latch, p0Out, p1Latch, p1Out;

    control_unit_if cu_if();

    control_unit #(.MFC_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .bus(cu_if), .MFC(MFC),
        .opControl(opControl),
        .ALUin0(ALUin0), .ALUin1(ALUin1), .ALUOutLatch(ALUOutLatch),
        .ALUOutEn(ALUOutEn), .PCOutEn(PCOutEn),
        .r0Latch(r0Latch), .r1Latch(r1Latch), .r2Latch(r2Latch), .r3Latch(r3Latch),
        .r0Out(r0Out), .r1Out(r1Out), .r2Out(r2Out), .r3Out(r3Out),
        .memEN(memEN), .memRW(memRW), .MARin(MARin),
        .MDRwriteEN(MDRwriteEN), .MDRreadEN(MDRreadEN), .MDRout(MDRout),
        .p0Latch(p0Latch), .p0Out(p0Out), .p1Latch(p1Latch), .p1Out(p1Out)
    );

    logic [22:0] strb;
    assign strb = {ALUin0, ALUin1, ALUOutLatch, ALUOutEn, PCOutEn,
                   r0Latch, r1Latch, r2Latch, r3Latch,
                   r0Out, r1Out, r2Out, r3Out,
                   memEN, memRW, MARin, MDRwriteEN, MDRreadEN, MDRout,
                   p0Latch, p0Out, p1Latch, p1Out};

    localparam logic [22:0] P1O = 23'(1) << 0;
    localparam logic [22:0] P1L = 23'(1) << 1;
    localparam logic [22:0] P0O = 23'(1) << 2;
    localparam logic [22:0] P0L = 23'(1) << 3;
    localparam logic [22:0] MDO = 23'(1) << 4;
    localparam logic [22:0] MRE = 23'(1) << 5;
    localparam logic [22:0] MWE = 23'(1) << 6;
    localparam logic [22:0] MAR = 23'(1) << 7;
    localparam logic [22:0] MRW = 23'(1) << 8;
    localparam logic [22:0] MEN = 23'(1) << 9;
    localparam logic [22:0] R3O = 23'(1) << 10;
    localparam logic [22:0] R2O = 23'(1) << 11;
    localparam logic [22:0] R1O = 23'(1) << 12;
    localparam logic [22:0] R0O = 23'(1) << 13;
    localparam logic [22:0] R3L = 23'(1) << 14;
    localparam logic [22:0] R2L = 23'(1) << 15;
    localparam logic [22:0] R1L = 23'(1) << 16;
    localparam logic [22:0] R0L = 23'(1) << 17;
    localparam logic [22:0] PCO = 23'(1) << 18;
    localparam logic [22:0] AOE = 23'(1) << 19;
    localparam logic [22:0] AOL = 23'(1) << 20;
    localparam logic [22:0] AI1 = 23'(1) << 21;
    localparam logic [22:0] AI0 = 23'(1) << 22;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic r, input logic d, input logic e,
                       input logic [2:0] op, input logic [22:0] s);
        logic [28:0] obs, exp;
        obs = {cu_if.ready, cu_if.done, cu_if.err, opControl, strb};
        exp = {r, d, e, op, s};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed {rdy,done,err,op,strb}=%h expected %h", tag, obs, exp);
        end
    endtask

    task automatic busy(input string tag, input logic [2:0] op, input logic [22:0] s);
        chk(tag, 1'b0, 1'b0, 1'b0, op, s);
    endtask

    task automatic idle(input string tag);
        chk(tag, 1'b1, 1'b0, 1'b0, 3'd0, 23'd0);
    endtask

    task automatic fin(input string tag, input logic e);
        chk(tag, 1'b0, 1'b1, e, 3'd0, 23'd0);
    endtask

    task automatic issue(input logic [15:0] w);
        cu_if.instr      = w;
        cu_if.instrValid = 1'b1;
        step;
        cu_if.instrValid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; MFC = 1'b0;
        cu_if.instr = 16'h0000; cu_if.instrValid = 1'b0;
        step; step;
        rst = 1'b0;
        idle("reset");

        // ADD r2 <- r2 + r1
        issue(16'h1900);
        busy("add_c1", 3'd1, R2O | AI0); step;
        busy("add_c2", 3'd1, R1O | AI1); step;
        busy("add_c3", 3'd1, AOL);       step;
        busy("add_c4", 3'd1, AOE | R2L); step;
        fin("add_done", 1'b0);           step;
        idle("add_idle");

        // Reset during ALU_B
        issue(16'h2C00);
        busy("rst_alu_a", 3'd2, R3O | AI0); step;
        busy("rst_alu_b", 3'd2, R0O | AI1);
        rst = 1'b1; step; rst = 1'b0;
        idle("rst_abort"); step;
        idle("rst_no_done");

        // ALU op 7 with rd = rs = r1
        issue(16'h7500);
        busy("alu7_c1", 3'd7, R1O | AI0); step;
        busy("alu7_c2", 3'd7, R1O | AI1); step;
        busy("alu7_c3", 3'd7, AOL);       step;
        busy("alu7_c4", 3'd7, AOE | R1L); step;
        fin("alu7_done", 1'b0);           step;
        idle("alu7_idle");

        // LOAD r0 <- mem[r3], MFC on the fourth L_RD cycle
        issue(16'h9300);
        busy("ld_mar", 3'd0, R3O | MAR); step;
        for (int i = 0; i < 4; i++) begin
            busy("ld_wait", 3'd0, MEN);
            if (i == 3) MFC = 1'b1;
            step;
        end
        MFC = 1'b0;
        busy("ld_lat", 3'd0, MEN | MRE); step;
        busy("ld_wb", 3'd0, MDO | R0L);  step;
        fin("ld_done", 1'b0);            step;
        idle("ld_idle");

        // STORE, IN, OUT back to back with instrValid held high
        cu_if.instr = 16'hA600; cu_if.instrValid = 1'b1;
        step;
        busy("st_mar", 3'd0, R2O | MAR); step;
        busy("st_mdr", 3'd0, R1O | MWE); step;
        busy("st_wr", 3'd0, MEN | MRW);
        MFC = 1'b1; step; MFC = 1'b0;
        fin("st_done", 1'b0);
        cu_if.instr = 16'hC400; step;
        idle("b2b_ready1"); step;
        busy("in_smp", 3'd0, P1L);       step;
        busy("in_wb", 3'd0, P1O | R1L);  step;
        fin("in_done", 1'b0);
        cu_if.instr = 16'hB800; step;
        idle("b2b_ready2"); step;
        busy("out_c1", 3'd0, R2O | P0L); step;
        fin("out_done", 1'b0);
        cu_if.instrValid = 1'b0; step;
        idle("b2b_end");

        // MOV r3 <- r1 with instr switched to PC-read while busy
        cu_if.instr = 16'h8D00; cu_if.instrValid = 1'b1;
        step;
        cu_if.instr = 16'hD000;
        busy("mov_xfer", 3'd0, R1O | R3L); step;
        fin("mov_done", 1'b0);             step;
        idle("mov_idle");                  step;
        cu_if.instrValid = 1'b0;
        busy("pc_wb", 3'd0, PCO | R0L);    step;
        fin("pc_done", 1'b0);              step;
        idle("pc_idle");

        // MOV r2 <- r2, then NOP
        issue(16'h8A00);
        busy("mov_same", 3'd0, R2O | R2L); step;
        fin("mov_same_done", 1'b0);        step;
        idle("mov_same_idle");
        issue(16'hF000);
        fin("nop_done", 1'b0);             step;
        idle("nop_idle");

`ifdef CU_MFC_TIMEOUT_EN
        // LOAD with MFC stuck low: abort after four wait cycles, no write-back
        issue(16'h9100);
        busy("to_mar", 3'd0, R1O | MAR); step;
        for (int i = 0; i < 4; i++) begin
            busy("to_wait", 3'd0, MEN);
            step;
        end
        fin("to_err", 1'b1); step;
        idle("to_idle");

        // STORE with MFC arriving exactly at the limit completes normally
        issue(16'hA600);
        busy("tl_mar", 3'd0, R2O | MAR); step;
        busy("tl_mdr", 3'd0, R1O | MWE); step;
        for (int i = 0; i < 4; i++) begin
            busy("tl_wait", 3'd0, MEN | MRW);
            if (i == 3) MFC = 1'b1;
            step;
        end
        MFC = 1'b0;
        fin("tl_done", 1'b0); step;
        idle("tl_idle");
`else
        // LOAD with a long MFC stall: no abort without the timeout feature
        issue(16'h9100);
        busy("lw_mar", 3'd0, R1O | MAR); step;
        for (int i = 0; i < 20; i++) begin
            busy("lw_wait", 3'd0, MEN);
            if (i == 19) MFC = 1'b1;
            step;
        end
        MFC = 1'b0;
        busy("lw_lat", 3'd0, MEN | MRE); step;
        busy("lw_wb", 3'd0, MDO | R0L);  step;
        fin("lw_done", 1'b0);            step;
        idle("lw_idle");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
